// File: rtl/instruction_loader.sv
// Boot-time instruction memory loader: assembles big-endian 32-bit words from a
// byte stream, writes them to instruction memory, verifies a trailing checksum.
module instruction_loader #(
    parameter int unsigned DEPTH     = 512,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  ByteIn,
    input  logic        ByteValid,
    output logic        ByteReady,
    output logic        WrEnable,
    output logic [31:0] WrAddress,
    output logic [31:0] WrData,
    output logic        CpuHold,
    output logic        Done,
    output logic        Error,
    output logic [1:0]  ErrCode,
    output logic [15:0] WordsLoaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_words_loaded;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [1:0]  r_err_code;

    logic [7:0]  r_hdr_hi;
    logic [15:0] r_word_total;
    logic [23:0] r_shift;
    logic [31:0] r_acc;

    logic        w_ready;
    logic        w_accept;
    logic        w_start_ok;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_overflow;
    logic [15:0] w_hdr_n;
    logic [31:0] w_word;

    assign w_accept    = ByteValid && w_ready;
    assign w_start_ok  = Start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
    assign w_hdr_n     = {r_hdr_hi, ByteIn};
    assign w_overflow  = {1'b0, w_hdr_n} > DEPTH_L;
    assign w_word      = {r_shift, ByteIn};
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == r_word_total - 16'd1);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The last word's write may still be in flight on entry to CHK; it lands in
    // the accumulator at least three cycles before the 4th checksum byte can arrive.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (Start) w_next_state = S_HDR_HI;
            S_HDR_HI: if (w_accept) w_next_state = S_HDR_LO;
            S_HDR_LO: begin
                if (w_accept) begin
                    if (w_overflow)           w_next_state = S_ERROR;
                    else if (w_hdr_n == 16'd0) w_next_state = S_CHK;
                    else                      w_next_state = S_DATA;
                end
            end
            S_DATA: if (w_accept && w_last_byte && w_last_word) w_next_state = S_CHK;
            S_CHK: begin
                if (w_accept && w_last_byte)
                    w_next_state = (w_word == r_acc) ? S_DONE : S_ERROR;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        Done    = 1'b0;
        Error   = 1'b0;
        CpuHold = 1'b1;
        case (r_state)
            S_HDR_HI, S_HDR_LO, S_DATA, S_CHK: w_ready = 1'b1;
            S_DONE: begin
                Done    = 1'b1;
                CpuHold = 1'b0;
            end
            S_ERROR: Error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_wr_en        <= 1'b0;
            r_wr_addr      <= 32'd0;
            r_wr_data      <= 32'd0;
            r_words_loaded <= 16'd0;
            r_word_idx     <= 16'd0;
            r_byte_idx     <= 2'd0;
            r_err_code     <= 2'd0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start_ok) begin
                r_words_loaded <= 16'd0;
                r_word_idx     <= 16'd0;
                r_byte_idx     <= 2'd0;
                r_err_code     <= 2'd0;
            end else begin
                if (r_wr_en) r_words_loaded <= r_words_loaded + 16'd1;
                if (w_accept) begin
                    case (r_state)
                        S_HDR_LO: begin
                            r_byte_idx <= 2'd0;
                            r_word_idx <= 16'd0;
                            if (w_overflow) r_err_code <= 2'd1;
                        end
                        S_DATA: begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (w_last_byte) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= BASE_ADDR + {14'd0, r_words_loaded, 2'b00};
                                r_wr_data  <= w_word;
                                r_word_idx <= r_word_idx + 16'd1;
                            end
                        end
                        S_CHK: begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            if (w_last_byte && (w_word != r_acc)) r_err_code <= 2'd2;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Datapath registers carry no reset; Start clears the accumulator before use.
    always_ff @(posedge Clk) begin
        if (w_start_ok) begin
            r_acc <= 32'd0;
        end else if (r_wr_en) begin
            r_acc <= r_acc + r_wr_data;
        end
        if (w_accept) begin
            r_shift <= w_word[23:0];
            if (r_state == S_HDR_HI) r_hdr_hi     <= ByteIn;
            if (r_state == S_HDR_LO) r_word_total <= w_hdr_n;
        end
    end

    assign ByteReady   = w_ready;
    assign WrEnable    = r_wr_en;
    assign WrAddress   = r_wr_addr;
    assign WrData      = r_wr_data;
    assign ErrCode     = r_err_code;
    assign WordsLoaded = r_words_loaded;

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized self-checking bench for instruction_loader against an image-level model.
`timescale 1ns/1ps
module tb_instruction_loader;

    localparam int          DEPTH = 512;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] bq_t [$];

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteIn = 8'h00;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        WrEnable;
    logic [31:0] WrAddress;
    logic [31:0] WrData;
    logic        CpuHold;
    logic        Done;
    logic        Error;
    logic [1:0]  ErrCode;
    logic [15:0] WordsLoaded;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] wr_q [$];

    always #5 Clk = ~Clk;

    instruction_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
        .ByteReady(ByteReady), .WrEnable(WrEnable), .WrAddress(WrAddress), .WrData(WrData),
        .CpuHold(CpuHold), .Done(Done), .Error(Error), .ErrCode(ErrCode),
        .WordsLoaded(WordsLoaded)
    );

    always @(negedge Clk) if (WrEnable) wr_q.push_back({WrAddress, WrData});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int max_gap, input bit noise);
        int g;
        int t;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        ByteValid = 1'b0;
        repeat (g) begin
            Start = noise && ($urandom_range(3, 0) == 0);
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        ByteIn = b;
        ByteValid = 1'b1;
        t = 0;
        while (!ByteReady && t < 50) begin
            @(posedge Clk); #1;
            t++;
        end
        if (!ByteReady) begin
            check("byte_ready_timeout", 32'(ByteReady), 32'd1);
            ByteValid = 1'b0;
            return;
        end
        Start = noise && ($urandom_range(3, 0) == 0);
        @(posedge Clk); #1;
        Start = 1'b0;
        ByteValid = 1'b0;
    endtask

    function automatic bq_t build_image(input int n, input bit corrupt);
        bq_t q;
        logic [31:0] w;
        logic [31:0] s;
        s = 32'd0;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n > DEPTH) return q;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            s = s + w;
            q.push_back(w[31:24]); q.push_back(w[23:16]);
            q.push_back(w[15:8]);  q.push_back(w[7:0]);
        end
        if (corrupt) s = s ^ (32'h1 << $urandom_range(31, 0));
        q.push_back(s[31:24]); q.push_back(s[23:16]);
        q.push_back(s[15:8]);  q.push_back(s[7:0]);
        return q;
    endfunction

    // Model: parse the image per the format rules and predict every write and the final status.
    task automatic run_load(input bq_t img, input int max_gap, input bit noise, input string name);
        int          n;
        int          code;
        int          nwr;
        logic [31:0] sum;
        logic [31:0] w;
        logic [31:0] chk;
        logic [63:0] exp_q [$];
        n = int'({img[0], img[1]});
        sum = 32'd0;
        if (n > DEPTH) begin
            code = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
                exp_q.push_back({BASE + 32'(4 * i), w});
                sum = sum + w;
            end
            chk = {img[2+4*n], img[3+4*n], img[4+4*n], img[5+4*n]};
            code = (chk == sum) ? 0 : 2;
        end

        pulse_start();
        check({name, ".start_hold"}, 32'(CpuHold), 32'd1);
        check({name, ".start_done"}, 32'(Done), 32'd0);
        check({name, ".start_err"}, 32'(Error), 32'd0);
        check({name, ".start_code"}, 32'(ErrCode), 32'd0);
        check({name, ".start_words"}, 32'(WordsLoaded), 32'd0);
        wr_q.delete();

        for (int i = 0; i < img.size(); i++) push_byte(img[i], max_gap, noise);
        repeat (3) @(posedge Clk);
        #1;

        check({name, ".nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check($sformatf("%s.addr%0d", name, i), wr_q[i][63:32], exp_q[i][63:32]);
            check($sformatf("%s.data%0d", name, i), wr_q[i][31:0], exp_q[i][31:0]);
        end
        check({name, ".done"}, 32'(Done), (code == 0) ? 32'd1 : 32'd0);
        check({name, ".error"}, 32'(Error), (code != 0) ? 32'd1 : 32'd0);
        check({name, ".code"}, 32'(ErrCode), 32'(code));
        check({name, ".hold"}, 32'(CpuHold), (code == 0) ? 32'd0 : 32'd1);
        check({name, ".words"}, 32'(WordsLoaded), (n > DEPTH) ? 32'd0 : 32'(n));
        check({name, ".ready"}, 32'(ByteReady), 32'd0);

        nwr = wr_q.size();
        ByteIn = 8'($urandom);
        ByteValid = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        ByteValid = 1'b0;
        check({name, ".idle_ready"}, 32'(ByteReady), 32'd0);
        check({name, ".idle_writes"}, 32'(wr_q.size()), 32'(nwr));
        check({name, ".idle_done"}, 32'(Done), (code == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t good;
        bq_t bad;
        bq_t empty;
        bq_t ovf;
        bq_t img;
        good  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09,
                  8'h50, 8'h20, 8'h21, 8'h11, 8'h50, 8'h25};
        bad   = good;
        bad[13] = 8'h26;
        empty = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        ovf   = '{8'h02, 8'h01};

        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst.ready", 32'(ByteReady), 32'd0);
        check("rst.wren", 32'(WrEnable), 32'd0);
        check("rst.addr", WrAddress, 32'd0);
        check("rst.data", WrData, 32'd0);
        check("rst.hold", 32'(CpuHold), 32'd1);
        check("rst.done", 32'(Done), 32'd0);
        check("rst.error", 32'(Error), 32'd0);
        check("rst.code", 32'(ErrCode), 32'd0);
        check("rst.words", 32'(WordsLoaded), 32'd0);

        Rst = 1'b1;
        ByteIn = 8'hAA;
        ByteValid = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        ByteValid = 1'b0;
        check("idle.ready", 32'(ByteReady), 32'd0);
        check("idle.hold", 32'(CpuHold), 32'd1);

        run_load(good, 0, 1'b0, "good");
        run_load(empty, 0, 1'b0, "empty");
        run_load(ovf, 0, 1'b0, "ovf");
        run_load(bad, 0, 1'b0, "badsum");
        run_load(good, 0, 1'b0, "reload");
        run_load(good, 4, 1'b1, "bubbles");

        // Reset after the 6th byte: first word already issued, loader returns to idle.
        pulse_start();
        for (int i = 0; i < 6; i++) push_byte(good[i], 0, 1'b0);
        Rst = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        check("rstA.wren", 32'(WrEnable), 32'd0);
        check("rstA.hold", 32'(CpuHold), 32'd1);
        check("rstA.words", 32'(WordsLoaded), 32'd0);
        check("rstA.ready", 32'(ByteReady), 32'd0);
        wr_q.delete();
        repeat (4) @(posedge Clk);
        #1;
        check("rstA.nwrites", 32'(wr_q.size()), 32'd0);

        // Reset coincident with the 4th byte of word 1: that write must never appear.
        pulse_start();
        wr_q.delete();
        for (int i = 0; i < 9; i++) push_byte(good[i], 0, 1'b0);
        ByteIn = good[9];
        ByteValid = 1'b1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b1;
        ByteValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("rstB.nwrites", 32'(wr_q.size()), 32'd1);
        check("rstB.words", 32'(WordsLoaded), 32'd0);
        check("rstB.hold", 32'(CpuHold), 32'd1);

        run_load(good, 2, 1'b1, "post_reset");

        for (int k = 0; k < 20; k++) begin
            img = build_image(int'($urandom_range(6, 0)), ($urandom_range(3, 0) == 0));
            run_load(img, int'($urandom_range(3, 0)), 1'b1, $sformatf("rand%0d", k));
        end

        run_load(build_image(DEPTH, 1'b0), 0, 1'b0, "full");
        run_load(build_image(int'($urandom_range(65535, DEPTH + 1)), 1'b0), 1, 1'b0, "ovf_rand");
        run_load(good, 0, 1'b0, "final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
